// File: rtl/gand16_checker_pkg.sv
// rtl/gand16_checker_pkg.sv - shared definitions for the gand16 response checker
//
// Purpose: FSM state encodings, default datapath/counter widths and the
//          saturating-counter ceiling used by gand16_checker and gand16_chk_cmp.
// Ports:   none (package).
package gand16_checker_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Largest value a w-bit unsigned counter can hold; counters stop here.
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/gand16_chk_cmp.sv
// rtl/gand16_chk_cmp.sv - combinational y versus a&b comparator
//
// Purpose: forms the reference a&b and flags a bitwise disagreement with y.
// Ports:   a_i, b_i     operands driven to the AND unit
//          y_i          AND unit result
//          cmp_mask_i   bits that take part in the compare (only when
//                       GAND16_CHK_MASK_EN is defined)
//          mismatch_o   1 when any compared bit of y differs from a&b
// Macro:   GAND16_CHK_MASK_EN adds cmp_mask_i; undefined compares all bits.
module gand16_chk_cmp
  import gand16_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] y_i,
`ifdef GAND16_CHK_MASK_EN
  input  logic [WIDTH-1:0] cmp_mask_i,
`endif
  output logic             mismatch_o
);

  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] diff;

  assign ref_val = a_i & b_i;
  assign diff    = y_i ^ ref_val;

`ifdef GAND16_CHK_MASK_EN
  assign mismatch_o = |(diff & cmp_mask_i);
`else
  assign mismatch_o = |diff;
`endif

endmodule

// File: rtl/gand16_checker.sv
// rtl/gand16_checker.sv - response checker for the 16-bit AND datapath
//
// Purpose: checks EXPECT_N vectors (a, b, y) against y == a&b, counts vectors
//          and mismatches (saturating), keeps the first failing vector and
//          reports done/pass at the end of the run.
// Ports:   clk, rst_n        clock, synchronous active-low reset
//          start             one-cycle pulse, begins a run from IDLE or DONE
//          in_valid, a, b, y vector to check this cycle (RUN only)
//          cmp_mask          compare mask (only with GAND16_CHK_MASK_EN)
//          busy, done, pass  run status; pass only meaningful with done
//          vec_cnt, err_cnt  accepted vectors / mismatches in current run
//          err_flag          sticky first-mismatch flag
//          first_a/b/y       first mismatching vector of the run
// Macro:   GAND16_CHK_MASK_EN enables the cmp_mask input.
module gand16_checker
  import gand16_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXPECT_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
`ifdef GAND16_CHK_MASK_EN
  input  logic [WIDTH-1:0] cmp_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_y
);

  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(sat_max(CNT_W));
  // vec_cnt value held while the final vector is being accepted.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EXPECT_N - 1);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_flag_q;
  logic [WIDTH-1:0] first_a_q;
  logic [WIDTH-1:0] first_b_q;
  logic [WIDTH-1:0] first_y_q;

  logic             mismatch;
  logic [CNT_W-1:0] vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             last_vec;

  gand16_chk_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a_i        (a),
    .b_i        (b),
    .y_i        (y),
`ifdef GAND16_CHK_MASK_EN
    .cmp_mask_i (cmp_mask),
`endif
    .mismatch_o (mismatch)
  );

  assign vec_cnt_d = vec_cnt_q + 1'b1;
  assign err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
  assign last_vec  = (vec_cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      first_a_q  <= '0;
      first_b_q  <= '0;
      first_y_q  <= '0;
    end else begin
      case (state_q)
        // IDLE and DONE only react to start; DONE otherwise holds its results.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            first_a_q  <= '0;
            first_b_q  <= '0;
            first_y_q  <= '0;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            vec_cnt_q <= vec_cnt_d;
            if (mismatch) begin
              err_cnt_q <= err_cnt_d;
              if (!err_flag_q) begin
                err_flag_q <= 1'b1;
                first_a_q  <= a;
                first_b_q  <= b;
                first_y_q  <= y;
              end
            end
            if (last_vec) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // The final vector's own compare must count towards pass.
              pass_q  <= (err_cnt_q == '0) && !mismatch;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
  assign first_a  = first_a_q;
  assign first_b  = first_b_q;
  assign first_y  = first_y_q;

endmodule

// File: tb/tb_gand16_checker.sv
// tb/tb_gand16_checker.sv - self-checking bench for gand16_checker
module tb_gand16_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, s_start, s_valid;
  logic [15:0] a, b, y;
  logic [15:0] cmp_mask = 16'hFFFF;

  logic        busy, done, pass, err_flag;
  logic [7:0]  vec_cnt, err_cnt;
  logic [15:0] first_a, first_b, first_y;

  logic        s_busy, s_done, s_pass, s_err_flag;
  logic [1:0]  s_vec_cnt, s_err_cnt;
  logic [15:0] s_first_a, s_first_b, s_first_y;

  int n_tests = 0;
  int n_fail  = 0;

  gand16_checker #(.WIDTH(16), .CNT_W(8), .EXPECT_N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .y(y),
`ifdef GAND16_CHK_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .first_a(first_a), .first_b(first_b), .first_y(first_y)
  );

  gand16_checker #(.WIDTH(16), .CNT_W(2), .EXPECT_N(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
    .a(a), .b(b), .y(y),
`ifdef GAND16_CHK_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .busy(s_busy), .done(s_done), .pass(s_pass), .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt),
    .err_flag(s_err_flag), .first_a(s_first_a), .first_b(s_first_b), .first_y(s_first_y)
  );

  // Reference model: the run is a list of vectors; results follow directly
  // from counting masked disagreements with a&b over that list.
  logic [15:0] qa[$], qb[$], qy[$];
  int          exp_err, exp_idx;
  logic [15:0] exp_fa, exp_fb, exp_fy;

  function automatic void model(input int sat);
    exp_err = 0; exp_idx = -1; exp_fa = 0; exp_fb = 0; exp_fy = 0;
    for (int i = 0; i < qa.size(); i++) begin
      if (((qy[i] ^ (qa[i] & qb[i])) & cmp_mask) != 16'h0) begin
        if (exp_err < sat) exp_err++;
        if (exp_idx < 0) begin
          exp_idx = i; exp_fa = qa[i]; exp_fb = qb[i]; exp_fy = qy[i];
        end
      end
    end
  endfunction

  function automatic void load4(input logic [15:0] y2, input logic [15:0] y3,
                                input logic [15:0] y4);
    qa = '{16'd0, 16'd0, 16'd1, 16'd1};
    qb = '{16'd0, 16'd1, 16'd0, 16'd1};
    qy = '{16'd0, y2, y3, y4};
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic send_all(input bit gaps);
    for (int i = 0; i < qa.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); y = 16'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1; a = qa[i]; b = qb[i]; y = qy[i];
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; s_start = 1'b0; s_valid = 1'b1;
    a = 16'hFFFF; b = 16'h00FF; y = 16'h1234;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, pass, err_flag} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, err_flag});
    end
    n_tests++;
    if (vec_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got vec=%0d err=%0d want 0 0", vec_cnt, err_cnt);
    end
    n_tests++;
    if ({first_a, first_b, first_y} !== 48'd0) begin
      n_fail++; $display("FAIL reset_first: got %h %h %h want 0", first_a, first_b, first_y);
    end
    rst_n = 1'b1; in_valid = 1'b0; s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    load4(16'd0, 16'd0, 16'd1);
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL clean_busy: got busy=%b done=%b want 1 0", busy, done);
    end
    send_all(1'b0);
    n_tests++;
    if (vec_cnt !== 8'd4 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clean_cnt: got vec=%0d err=%0d want 4 0", vec_cnt, err_cnt);
    end
    n_tests++;
    if ({busy, done, pass, err_flag} !== 4'b0110) begin
      n_fail++; $display("FAIL clean_status: got %b want 0110", {busy, done, pass, err_flag});
    end
  endtask

  task automatic test_single_error();
    load4(16'd0, 16'h0001, 16'd1);
    pulse_start();
    in_valid = 1'b1; a = 16'd0; b = 16'd0; y = 16'd0; @(negedge clk);
    a = 16'd0; b = 16'd1; y = 16'd0; @(negedge clk);
    a = 16'd1; b = 16'd0; y = 16'd1; @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd1 || err_flag !== 1'b1) begin
      n_fail++; $display("FAIL single_mid: got done=%b pass=%b err=%0d flag=%b want 0 0 1 1",
                         done, pass, err_cnt, err_flag);
    end
    in_valid = 1'b1; a = 16'd1; b = 16'd1; y = 16'd1; @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (err_cnt !== 8'd1 || done !== 1'b1 || pass !== 1'b0) begin
      n_fail++; $display("FAIL single_end: got err=%0d done=%b pass=%b want 1 1 0", err_cnt, done, pass);
    end
    n_tests++;
    if (first_a !== 16'd1 || first_b !== 16'd0 || first_y !== 16'd1) begin
      n_fail++; $display("FAIL single_first: got %h %h %h want 0001 0000 0001", first_a, first_b, first_y);
    end
  endtask

  task automatic test_first_hold();
    load4(16'd1, 16'd0, 16'd0);
    pulse_start();
    n_tests++;
    if (err_flag !== 1'b0 || err_cnt !== 8'd0 || first_a !== 16'd0 || first_y !== 16'd0) begin
      n_fail++; $display("FAIL hold_clear: got flag=%b err=%0d fa=%h fy=%h want 0", err_flag, err_cnt, first_a, first_y);
    end
    send_all(1'b0);
    n_tests++;
    if (err_cnt !== 8'd2 || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL hold_err: got err=%0d pass=%b done=%b want 2 0 1", err_cnt, pass, done);
    end
    n_tests++;
    if (first_a !== 16'd0 || first_b !== 16'd1 || first_y !== 16'd1) begin
      n_fail++; $display("FAIL hold_first: got %h %h %h want 0000 0001 0001", first_a, first_b, first_y);
    end
  endtask

  task automatic test_stall_ignore();
    // in_valid in DONE must not touch the held results.
    in_valid = 1'b1; a = 16'd3; b = 16'd3; y = 16'd0; @(negedge clk); in_valid = 1'b0;
    n_tests++;
    if (vec_cnt !== 8'd4 || err_cnt !== 8'd2 || done !== 1'b1) begin
      n_fail++; $display("FAIL done_ignore: got vec=%0d err=%0d done=%b want 4 2 1", vec_cnt, err_cnt, done);
    end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; y = 16'hFFFF; repeat (2) @(negedge clk); in_valid = 1'b0;
    n_tests++;
    if (vec_cnt !== 8'd0 || err_cnt !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got vec=%0d err=%0d busy=%b want 0 0 0", vec_cnt, err_cnt, busy);
    end
    pulse_start();
    qa = '{16'h00F0, 16'h0F0F}; qb = '{16'h0FF0, 16'hFFFF}; qy = '{16'h00F0, 16'h0F0F};
    send_all(1'b0);
    a = 16'h1; b = 16'h1; y = 16'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (vec_cnt !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL stall: got vec=%0d busy=%b done=%b want 2 1 0", vec_cnt, busy, done);
    end
    pulse_start();
    n_tests++;
    if (vec_cnt !== 8'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL run_start_ignore: got vec=%0d busy=%b want 2 1", vec_cnt, busy);
    end
    send_all(1'b0);
    n_tests++;
    if (vec_cnt !== 8'd4 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL stall_end: got vec=%0d done=%b pass=%b want 4 1 1", vec_cnt, done, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0F0F; y = 16'h000F; @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; y = 16'h0000; @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    n_tests++;
    if ({busy, done, pass, err_flag} !== 4'b0 || vec_cnt !== 8'd0 || err_cnt !== 8'd0 ||
        {first_a, first_b, first_y} !== 48'd0) begin
      n_fail++; $display("FAIL midrst: got flags=%b vec=%0d err=%0d fa=%h want all 0",
                         {busy, done, pass, err_flag}, vec_cnt, err_cnt, first_a);
    end
    qa.delete(); qb.delete(); qy.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(16'($urandom)); qb.push_back(16'($urandom)); qy.push_back(qa[i] & qb[i]);
    end
    pulse_start();
    send_all(1'b0);
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL midrst_rerun: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    load4(16'd1, 16'd0, 16'd0);
    pulse_start(); send_all(1'b0);
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || vec_cnt !== 8'd0 || err_cnt !== 8'd0 ||
        err_flag !== 1'b0 || first_b !== 16'd0 || first_y !== 16'd0) begin
      n_fail++; $display("FAIL b2b_clear: got busy=%b done=%b vec=%0d err=%0d flag=%b fb=%h want 1 0 0 0 0 0",
                         busy, done, vec_cnt, err_cnt, err_flag, first_b);
    end
    // Random runs back to back, with random gaps and random error injection.
    for (int r = 0; r < 24; r++) begin
      qa.delete(); qb.delete(); qy.delete();
      for (int i = 0; i < 4; i++) begin
        logic [15:0] ra, rb, flip;
        ra = 16'($urandom); rb = 16'($urandom);
        flip = ($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
        qa.push_back(ra); qb.push_back(rb); qy.push_back((ra & rb) ^ flip);
      end
      model(255);
      send_all(1'b1);
      n_tests++;
      if (vec_cnt !== 8'd4 || err_cnt !== 8'(exp_err) || done !== 1'b1 ||
          pass !== (exp_err == 0) || err_flag !== (exp_idx >= 0)) begin
        n_fail++; $display("FAIL rand_%0d_cnt: got vec=%0d err=%0d done=%b pass=%b flag=%b want 4 %0d 1 %b %b",
                           r, vec_cnt, err_cnt, done, pass, err_flag, exp_err, exp_err == 0, exp_idx >= 0);
      end
      n_tests++;
      if (first_a !== exp_fa || first_b !== exp_fb || first_y !== exp_fy) begin
        n_fail++; $display("FAIL rand_%0d_first: got %h %h %h want %h %h %h",
                           r, first_a, first_b, first_y, exp_fa, exp_fb, exp_fy);
      end
      pulse_start();
    end
    qa.delete(); qb.delete(); qy.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(16'd0); qb.push_back(16'd0); qy.push_back(16'd0);
    end
    send_all(1'b0);
  endtask

  task automatic test_saturation();
    qa = '{16'h0003, 16'hFFFF, 16'h8000}; qb = '{16'h0001, 16'h0000, 16'h8000};
    qy = '{16'h0000, 16'h0001, 16'h0000};
    model(3);
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; a = qa[i]; b = qb[i]; y = qy[i]; @(negedge clk);
    end
    s_valid = 1'b0;
    n_tests++;
    if (s_err_cnt !== 2'(exp_err) || s_vec_cnt !== 2'd3 || s_done !== 1'b1 || s_pass !== 1'b0) begin
      n_fail++; $display("FAIL sat: got err=%0d vec=%0d done=%b pass=%b want %0d 3 1 0",
                         s_err_cnt, s_vec_cnt, s_done, s_pass, exp_err);
    end
    n_tests++;
    if (s_first_a !== 16'h0003 || s_first_b !== 16'h0001 || s_first_y !== 16'h0000) begin
      n_fail++; $display("FAIL sat_first: got %h %h %h want 0003 0001 0000", s_first_a, s_first_b, s_first_y);
    end
  endtask

`ifdef GAND16_CHK_MASK_EN
  task automatic test_mask();
    cmp_mask = 16'hFFFE;
    load4(16'd0, 16'd0, 16'd1);
    qy[0] = 16'h0001;
    model(255);
    pulse_start(); send_all(1'b0);
    n_tests++;
    if (err_cnt !== 8'(exp_err) || pass !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL mask_lsb: got err=%0d pass=%b want %0d 1", err_cnt, pass, exp_err);
    end
    cmp_mask = 16'h0000;
    load4(16'hFFFF, 16'h1234, 16'h0000);
    pulse_start(); send_all(1'b0);
    n_tests++;
    if (err_cnt !== 8'd0 || pass !== 1'b1) begin
      n_fail++; $display("FAIL mask_zero: got err=%0d pass=%b want 0 1", err_cnt, pass);
    end
    cmp_mask = 16'hFFFF;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_valid = 1'b0;
    a = 16'd0; b = 16'd0; y = 16'd0;
    @(negedge clk);
    test_reset();
    test_clean();
    test_single_error();
    test_first_hold();
    test_stall_ignore();
    test_reset_mid_run();
    test_back_to_back();
    test_saturation();
`ifdef GAND16_CHK_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gand16_checker.md
Name: gand16_checker

Overview:
- Synthesizable response checker for the 16-bit AND datapath; it consumes the interface that the stimulus side drives.
- Samples an operand pair (a, b) together with the DUT result y, and compares y against a&b.
- Counts vectors and mismatches, and captures the first failing vector.
- Reports pass/fail once a programmed number of vectors has been checked.
- Sits beside the AND unit in the trab1 harness; can run in simulation or on an FPGA board with LEDs on pass/done.

Parameters:
- WIDTH, 16, operand and result width
- CNT_W, 8, width of vector and error counters
- EXPECT_N, 4, number of vectors to check before DONE (1 .. 2^CNT_W-1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a check run
- in_valid  input  1  a, b, y hold a vector to be checked this cycle
- a  input  WIDTH  operand A driven to the DUT
- b  input  WIDTH  operand B driven to the DUT
- y  input  WIDTH  DUT result
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pass  output  1  valid when done; 1 if err_cnt==0
- vec_cnt  output  CNT_W  vectors accepted in current run
- err_cnt  output  CNT_W  mismatches in current run, saturating
- err_flag  output  1  sticky; set on first mismatch of run
- first_a  output  WIDTH  a of first mismatching vector
- first_b  output  WIDTH  b of first mismatching vector
- first_y  output  WIDTH  y of first mismatching vector

Behaviour:
- Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk. While rst_n=0: state=IDLE; busy, done, pass, err_flag = 0; vec_cnt, err_cnt = 0; first_a, first_b, first_y = 0.
- Reset asserted mid-run aborts the run immediately, and all outputs take their reset values on that edge.
- FSM, IDLE state:
  - start=1 -> RUN; the same edge clears the counters, err_flag and the first_* registers.
  - in_valid is ignored.
- FSM, RUN state:
  - Each edge with in_valid=1 accepts one vector.
  - vec_cnt += 1.
  - On mismatch (y != (a&b)), err_cnt += 1, holding at 2^CNT_W-1 (saturating).
  - On a mismatch while err_flag=0, set err_flag and latch first_a/b/y. Later mismatches never overwrite first_*.
  - start is ignored in RUN.
  - On the edge accepting vector number EXPECT_N -> DONE.
- FSM, DONE state:
  - done=1 and pass=(err_cnt==0); counters and first_* hold.
  - in_valid is ignored.
  - start=1 -> RUN with the same clearing as in IDLE, so back-to-back runs need no IDLE cycle.
- Latency: counter and flag updates are visible the cycle after the accepting edge; done rises the cycle after the EXPECT_N-th vector.
- Comparison is purely bitwise over WIDTH bits; no arithmetic on operands.
- The comparison and the final-vector condition are evaluated on the same edge. A mismatch on vector EXPECT_N is therefore counted, and pass=0 when done rises.
- in_valid gaps in RUN simply stall; there is no timeout.
- pass is 0 whenever done=0.

Optional Feature:
- Macro: GAND16_CHK_MASK_EN.
- Defined:
  - Adds input port cmp_mask [WIDTH-1:0].
  - A mismatch is ((y ^ (a&b)) & cmp_mask) != 0.
  - cmp_mask=0 makes every vector pass.
- Undefined: no port; all WIDTH bits are compared.

Decomposition:
- Shared include file gand16_defs.vh holds:
  - the FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH/CNT_W constants;
  - the saturating-max localparam expression.
- One natural sub-module, gand16_chk_cmp:
  - combinational ref=a&b, mismatch bit, optional mask.
  - Instantiated once; lets the compare be unit-tested alone.

Test Plan:
- Clean run: start, then in sequence (a,b,y) = (0,0,0), (0,1,0), (1,0,0), (1,1,1) with in_valid=1 each cycle -> vec_cnt=4, err_cnt=0, done=1, pass=1, err_flag=0.
- Single error: same sequence but third vector y=16'h0001 -> err_cnt=1, err_flag=1, first_a=1, first_b=0, first_y=1, pass=0.
- First-error hold: errors on vectors 2 (a=0,b=1,y=1) and 4 (a=1,b=1,y=0) -> err_cnt=2, first_a=0, first_b=1, first_y=1.
- Stall and ignore:
  - in_valid low for 3 cycles mid-run -> vec_cnt frozen, busy=1.
  - start pulsed in RUN -> no effect.
  - in_valid in IDLE -> vec_cnt stays 0.
- Reset mid-run: after 2 vectors with 1 error, rst_n=0 for one edge -> all outputs 0, state IDLE. A following start plus 4 clean vectors -> pass=1.
- Back-to-back runs and saturation:
  - start in DONE restarts with cleared counters.
  - With CNT_W=2, EXPECT_N=3 and all 3 vectors failing -> err_cnt=3, the 2-bit maximum. The counter reaches its ceiling without wrapping; the saturate-and-hold path itself is exercised at unit level or under a larger EXPECT_N.
  - With GAND16_CHK_MASK_EN and cmp_mask=16'hFFFE, y=16'h0001 for a=b=0 -> no error.
